// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output stage and its timebase.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int unsigned DEFAULT_PRESCALE = 13;

    typedef enum logic [1:0] {
        PIN_OFF,
        PIN_HIGH,
        PIN_PWM
    } pin_mode_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled free-running 8-bit PWM counter with an end-of-period strobe.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 pwm_period_start
);

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    logic [7:0] prescaler;
    logic       tick;

    assign tick             = (prescaler == PS_LAST);
    assign pwm_period_start = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 8'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// Drives 16 pins as off, static-high or PWM from SPI-written enables and a shadowed duty byte.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [7:0]           pwm_duty_cycle,
    output logic [7:0]           uo_out,
    output logic [7:0]           uio_out,
    output logic                 pwm_period_start,
    output logic [PWM_CNT_W-1:0] pwm_cnt
);

    logic [PWM_CNT_W-1:0] duty_q;
    logic                 pwm_raw;
    logic [15:0]          en_out;
    logic [15:0]          en_pwm;
    logic [15:0]          next_out;
    logic [15:0]          out_q;

    pwm_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk             (clk),
        .rst_n           (rst_n),
        .pwm_cnt         (pwm_cnt),
        .pwm_period_start(pwm_period_start)
    );

    // Duty is only picked up on the 255 -> 0 wrap so a period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else if (pwm_period_start) begin
            duty_q <= pwm_duty_cycle;
        end
    end

    assign pwm_raw = (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);
    assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        next_out = '0;
        for (int i = 0; i < 16; i++) begin
            next_out[i] = en_out[i] && (en_pwm[i] ? pwm_raw : 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= next_out;
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench: vector table, period measurements and a cycle-level phase-based model.
module tb_pwm_output_stage;
    import pwm_pkg::*;

    localparam int unsigned P      = DEFAULT_PRESCALE;
    localparam int unsigned PERIOD = 256 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] uo_out, uio_out, pwm_cnt;
    logic       pwm_period_start;

    always #5 clk = ~clk;

    pwm_output_stage #(
        .PRESCALE(P)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .uo_out          (uo_out),
        .uio_out         (uio_out),
        .pwm_period_start(pwm_period_start),
        .pwm_cnt         (pwm_cnt)
    );

    logic [15:0] en_out16, en_pwm16, dut_out;
    assign en_out16 = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm16 = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign dut_out  = {uio_out, uo_out};

    int n_checks = 0;
    int n_fail   = 0;
    bit bg_en    = 1'b0;

    // Reference: pin level derived from elapsed time in the period, not from a counter compare.
    function automatic logic [15:0] ref_out(input logic [15:0] eo, input logic [15:0] ep,
                                            input logic [7:0] d, input int unsigned n);
        int unsigned phase;
        logic        level;
        pin_mode_e   mode;
        logic [15:0] r;
        phase = n % PERIOD;
        level = (d == 8'hFF) || (phase < int'(d) * P);
        r = '0;
        for (int i = 0; i < 16; i++) begin
            mode = !eo[i] ? PIN_OFF : (ep[i] ? PIN_PWM : PIN_HIGH);
            case (mode)
                PIN_OFF:  r[i] = 1'b0;
                PIN_HIGH: r[i] = 1'b1;
                default:  r[i] = level;
            endcase
        end
        return r;
    endfunction

    int unsigned m_n;
    logic [7:0]  m_duty;
    logic [15:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_duty <= 8'h00;
            m_out  <= '0;
        end else begin
            m_out <= ref_out(en_out16, en_pwm16, m_duty, m_n);
            if (m_n % PERIOD == PERIOD - 1) m_duty <= pwm_duty_cycle;
            m_n <= m_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
        pwm_duty_cycle = d;
    endtask

    task automatic wait_start(input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (pwm_period_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_start: no period start within %0d clks", bound);
        end
    endtask

    // One window from just after a period start up to and including the next one.
    task automatic measure(input logic chg_en, input logic [7:0] chg_at, input logic [7:0] chg_val,
                           output int len, output int hi0, output int hi4, output int skew);
        logic [15:0] mask;
        mask = en_out16 & en_pwm16;
        len = 0; hi0 = 0; hi4 = 0; skew = 0;
        for (int k = 1; k <= int'(PERIOD) + 200; k++) begin
            @(negedge clk);
            len = k;
            if (dut_out[0]) hi0++;
            if (dut_out[4]) hi4++;
            if (((dut_out ^ {16{dut_out[0]}}) & mask) != 16'h0) skew++;
            if (chg_en && pwm_cnt == chg_at) pwm_duty_cycle = chg_val;
            if (pwm_period_start) break;
        end
    endtask

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int len, hi0, hi4, skew, k;
        logic [15:0] prev;
        logic [7:0]  d;
        int unsigned r;

        // Duty is still 0 inside the first period, so PWM pins read low whatever the input says.
        vecs[0] = '{16'h0001, 16'h0000, 8'h00, 16'h0001};
        vecs[1] = '{16'h8001, 16'h0000, 8'h00, 16'h8001};
        vecs[2] = '{16'h0000, 16'h0000, 8'h00, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'h0000, 8'hFF, 16'hFFFF};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[5] = '{16'h0000, 16'hFFFF, 8'h80, 16'h0000};
        vecs[6] = '{16'h00FF, 16'h0F0F, 8'h80, 16'h00F0};
        vecs[7] = '{16'hA5A5, 16'h00FF, 8'h40, 16'hA500};

        drive(16'hFFFF, 16'hFFFF, 8'hFF);
        fork
            forever begin
                @(negedge clk);
                if (bg_en) begin
                    check("model_out", 32'(dut_out), 32'(m_out));
                    check("model_cnt", 32'(pwm_cnt), 32'((m_n / P) % 256));
                    check("model_start", 32'(pwm_period_start), 32'(m_n % PERIOD == PERIOD - 1));
                end
            end
        join_none

        repeat (5) @(posedge clk);
        #1;
        check("reset_uo", 32'(uo_out), 32'h0);
        check("reset_uio", 32'(uio_out), 32'h0);
        check("reset_cnt", 32'(pwm_cnt), 32'h0);
        check("reset_start", 32'(pwm_period_start), 32'h0);
        bg_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].eo, vecs[i].ep, vecs[i].duty);
            #1 check($sformatf("vec%0d_hold", i), 32'(dut_out), 32'(prev));
            @(posedge clk);
            #1 check($sformatf("vec%0d_out", i), 32'(dut_out), 32'(vecs[i].exp_out));
            prev = vecs[i].exp_out;
        end

        // 50 % duty on every pin
        drive(16'hFFFF, 16'hFFFF, 8'h80);
        wait_start(PERIOD + 10);
        for (int i = 0; i < 2; i++) begin
            measure(1'b0, 8'h00, 8'h00, len, hi0, hi4, skew);
            check("half_len", 32'(len), 32'(PERIOD));
            check("half_hi", 32'(hi0), 32'(128 * P));
            check("half_skew", 32'(skew), 32'h0);
        end

        // Duty extremes with a mix of PWM and static pins
        for (int j = 0; j < 2; j++) begin
            d = (j == 0) ? 8'h00 : 8'hFF;
            drive(16'hFFFF, 16'h0F0F, d);
            wait_start(PERIOD + 10);
            wait_start(PERIOD + 10);
            for (int i = 0; i < 2; i++) begin
                measure(1'b0, 8'h00, 8'h00, len, hi0, hi4, skew);
                check($sformatf("dut%0h_len", d), 32'(len), 32'(PERIOD));
                check($sformatf("dut%0h_pwm_hi", d), 32'(hi0), (j == 0) ? 32'h0 : 32'(PERIOD));
                check($sformatf("dut%0h_static_hi", d), 32'(hi4), 32'(PERIOD));
                check($sformatf("dut%0h_skew", d), 32'(skew), 32'h0);
            end
        end

        // Mid-period duty change is deferred to the next period
        drive(16'hFFFF, 16'hFFFF, 8'h40);
        wait_start(PERIOD + 10);
        wait_start(PERIOD + 10);
        measure(1'b1, 8'h10, 8'hC0, len, hi0, hi4, skew);
        check("shadow_cur_hi", 32'(hi0), 32'(64 * P));
        measure(1'b0, 8'h00, 8'h00, len, hi0, hi4, skew);
        check("shadow_next_hi", 32'(hi0), 32'(192 * P));

        // Random enables/duty, checked cycle by cycle against the model
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            r = $urandom;
            case (r % 4)
                0:       d = 8'hFF;
                1:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            drive(16'($urandom), 16'($urandom), d);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        // Reset mid-period
        drive(16'hFFFF, 16'hFFFF, 8'hFF);
        k = 0;
        for (int i = 0; i < int'(PERIOD) + 10; i++) begin
            @(negedge clk);
            k = i;
            if (pwm_cnt == 8'h77) break;
        end
        check("mid_cnt_reached", 32'(pwm_cnt), 32'h77);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(dut_out), 32'h0);
        check("mid_rst_cnt", 32'(pwm_cnt), 32'h0);
        check("mid_rst_start", 32'(pwm_period_start), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hi0 = 0;
        k = 0;
        for (int i = 1; i <= int'(PERIOD) + 200; i++) begin
            @(negedge clk);
            k = i;
            if (dut_out[0]) hi0++;
            if (pwm_period_start) break;
        end
        check("post_rst_first_start", 32'(k), 32'(PERIOD));
        check("post_rst_first_hi", 32'(hi0), 32'h0);

        bg_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
